// File: rtl/ram_arbiter_pkg.sv
// Shared types and widths for the SRAM port arbiter.
package ram_arbiter_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BOOT = 2'd1,
    OWN_IF   = 2'd2,
    OWN_MEM  = 2'd3
  } owner_t;

endpackage

// File: rtl/ram_arbiter.sv
// Arbiter sharing one SRAM controller port between the bootloader, CPU
// instruction fetch and CPU data access. One transfer in flight at a time;
// every transfer is followed by a one-cycle gap before the next grant.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MEM_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_done,
  input  logic              boot_need_to_work,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] boot_data,
  output logic              boot_work_done,
  input  logic              if_need_to_work,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_work_done,
  input  logic              mem_need_to_work,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_work_done,
  output logic [DATA_W-1:0] rdata_out,
  output logic              ram_need_to_work,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in,
  input  logic              ram_work_done,
  output logic              timeout_err
);

  localparam logic [7:0] STREAK_MAX = 8'(MEM_STREAK_MAX);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nxt;
  owner_t     owner, grant;
  logic [7:0] streak;
  logic [7:0] tcnt;
  logic       busy_done, busy_to, owner_reads;

  // Streak counter never wraps: it parks at the limit until IF is served.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == STREAK_MAX) ? v : v + 8'd1;
  endfunction

  // Completion wins over an expiring timeout in the same cycle.
  assign busy_done   = (state == ST_BUSY) && ram_work_done;
  assign busy_to     = (state == ST_BUSY) && !ram_work_done && (tcnt == TO_LAST);
  assign owner_reads = (owner == OWN_IF) || ((owner == OWN_MEM) && !ram_we);

  // Grant selection: boot alone before boot_done, then MEM over IF unless IF has waited out a full MEM streak.
  always_comb begin
    grant = OWN_NONE;
    if (!boot_done) begin
      if (boot_need_to_work) grant = OWN_BOOT;
    end else if (if_need_to_work && (!mem_need_to_work || streak == STREAK_MAX)) begin
      grant = OWN_IF;
    end else if (mem_need_to_work) begin
      grant = OWN_MEM;
    end
  end

  // Next-state logic for the IDLE -> BUSY -> GAP transfer cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant != OWN_NONE) state_nxt = ST_BUSY;
      ST_BUSY: if (busy_done || busy_to) state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Transfer registers: capture the owner's request at grant, hold it while busy, issue done pulses and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner            <= OWN_NONE;
      streak           <= '0;
      tcnt             <= '0;
      ram_need_to_work <= 1'b0;
      ram_we           <= 1'b0;
      ram_addr_out     <= '0;
      ram_data_out     <= '0;
      rdata_out        <= '0;
      boot_work_done   <= 1'b0;
      if_work_done     <= 1'b0;
      mem_work_done    <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      boot_work_done <= 1'b0;
      if_work_done   <= 1'b0;
      mem_work_done  <= 1'b0;
      timeout_err    <= 1'b0;
      if (!if_need_to_work) streak <= '0;

      if (state == ST_IDLE && grant != OWN_NONE) begin
        owner            <= grant;
        ram_need_to_work <= 1'b1;
        tcnt             <= '0;
        case (grant)
          OWN_BOOT: begin
            ram_addr_out <= boot_addr;
            ram_data_out <= boot_data;
            ram_we       <= 1'b1;
          end
          OWN_IF: begin
            ram_addr_out <= if_addr;
            ram_data_out <= '0;
            ram_we       <= 1'b0;
            streak       <= '0;
          end
          OWN_MEM: begin
            ram_addr_out <= mem_addr;
            ram_data_out <= mem_wdata;
            ram_we       <= mem_we;
            if (if_need_to_work) streak <= sat_inc(streak);
          end
          default: ;
        endcase
      end

      if (busy_done || busy_to) begin
        ram_need_to_work <= 1'b0;
        case (owner)
          OWN_BOOT: boot_work_done <= 1'b1;
          OWN_IF:   if_work_done   <= 1'b1;
          OWN_MEM:  mem_work_done  <= 1'b1;
          default: ;
        endcase
        if (busy_to) begin
          timeout_err <= 1'b1;
          rdata_out   <= '0;
        end else if (owner_reads) begin
          rdata_out <= ram_data_in;
        end
      end else if (state == ST_BUSY) begin
        tcnt <= tcnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural SRAM responder, golden memory,
// vector table, directed corner sequences and a randomized two-master run.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        boot_done = 1'b0;
  logic        boot_need_to_work = 1'b0;
  logic [17:0] boot_addr = '0;
  logic [15:0] boot_data = '0;
  logic        boot_work_done;
  logic        if_need_to_work = 1'b0;
  logic [17:0] if_addr = '0;
  logic        if_work_done;
  logic        mem_need_to_work = 1'b0;
  logic        mem_we = 1'b0;
  logic [17:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic        mem_work_done;
  logic [15:0] rdata_out;
  logic        ram_need_to_work;
  logic        ram_we;
  logic [17:0] ram_addr_out;
  logic [15:0] ram_data_out;
  logic [15:0] ram_data_in = '0;
  logic        ram_work_done = 1'b0;
  logic        timeout_err;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .boot_need_to_work(boot_need_to_work), .boot_addr(boot_addr), .boot_data(boot_data),
    .boot_work_done(boot_work_done),
    .if_need_to_work(if_need_to_work), .if_addr(if_addr), .if_work_done(if_work_done),
    .mem_need_to_work(mem_need_to_work), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_work_done(mem_work_done),
    .rdata_out(rdata_out),
    .ram_need_to_work(ram_need_to_work), .ram_we(ram_we), .ram_addr_out(ram_addr_out),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in), .ram_work_done(ram_work_done),
    .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- SRAM model and golden memory ----------------
  logic [15:0] sram_w [int];
  logic [15:0] gold [int];

  function automatic logic [15:0] init_val(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] gold_rd(input logic [17:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : init_val(a);
  endfunction

  int          lat_cfg = 2;     // 0 selects a random latency 1..4
  bit          no_resp = 1'b0;
  bit          sr_active = 1'b0;
  int          sr_cnt = 0, sr_lat = 0;
  int unsigned done_cyc = 0;
  int          grants = 0;
  int          frozen_err = 0;
  logic [17:0] log_addr = '0;
  logic        log_we = 1'b0;
  logic [15:0] log_data = '0;

  initial begin : responder
    forever begin
      @(negedge clk);
      ram_work_done = 1'b0;
      if (!rst || !ram_need_to_work) begin
        sr_active = 1'b0;
      end else begin
        if (!sr_active) begin
          sr_active = 1'b1;
          sr_cnt    = 0;
          sr_lat    = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
          log_addr  = ram_addr_out;
          log_we    = ram_we;
          log_data  = ram_data_out;
          grants++;
        end
        if (ram_addr_out !== log_addr || ram_we !== log_we || ram_data_out !== log_data)
          frozen_err++;
        if (!no_resp) begin
          sr_cnt++;
          if (sr_cnt == sr_lat) begin
            ram_work_done = 1'b1;
            done_cyc      = cyc;
            if (ram_we) sram_w[int'(ram_addr_out)] = ram_data_out;
            else ram_data_in = sram_w.exists(int'(ram_addr_out)) ? sram_w[int'(ram_addr_out)]
                                                                 : init_val(ram_addr_out);
          end
        end
      end
    end
  end

  // ---------------- pulse-shape monitor ----------------
  int   pulse_err = 0;
  int   if_done_cnt = 0;
  logic p_b = 0, p_i = 0, p_m = 0, p_t = 0;
  initial begin : pulse_mon
    forever begin
      @(negedge clk);
      if (int'(boot_work_done) + int'(if_work_done) + int'(mem_work_done) > 1) pulse_err++;
      if ((boot_work_done && p_b) || (if_work_done && p_i) || (mem_work_done && p_m) ||
          (timeout_err && p_t)) pulse_err++;
      if (if_work_done) if_done_cnt++;
      p_b = boot_work_done; p_i = if_work_done; p_m = mem_work_done; p_t = timeout_err;
    end
  end

  // ---------------- arbitration reference (random phase) ----------------
  bit          mon_on = 1'b0;
  int          exp_q[$];
  int          ms = 0;           // consecutive MEM grants during the current IF wait
  int          mon_e = 0, mon_g = 0;
  int unsigned if_low_cnt = 0, seen_low = 0;
  logic        snap_if = 1'b0, snap_mem = 1'b0, prev_need = 1'b0;

  always @(posedge clk) begin
    snap_if  <= if_need_to_work;
    snap_mem <= mem_need_to_work;
    if (!if_need_to_work) if_low_cnt <= if_low_cnt + 1;
  end

  initial begin : arb_mon
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (ram_need_to_work && !prev_need) begin
          if (if_low_cnt != seen_low) ms = 0;
          seen_low = if_low_cnt;
          if (snap_if && (!snap_mem || ms >= 4)) begin mon_e = 1; ms = 0; end
          else if (snap_mem) begin mon_e = 2; if (snap_if) ms++; end
          else mon_e = 0;
          exp_q.push_back(mon_e);
        end
        if (mem_work_done || if_work_done) begin
          mon_g = mem_work_done ? 2 : 1;
          if (exp_q.size() == 0) check("rnd owner (no grant seen)", mon_g, 0);
          else check("rnd owner", mon_g, exp_q.pop_front());
        end
      end
      prev_need = ram_need_to_work;
    end
  end

  // ---------------- requester task (called at a negedge) ----------------
  task automatic txn(input int src, input logic we, input logic [17:0] addr, input logic [15:0] data,
                     output logic [15:0] rd, output logic to_seen, output int lat_obs);
    bit ok = 1'b0;
    rd = '0; to_seen = 1'b0; lat_obs = -1;
    case (src)
      0: begin boot_addr = addr; boot_data = data; boot_need_to_work = 1'b1; end
      1: begin if_addr = addr; if_need_to_work = 1'b1; end
      default: begin mem_we = we; mem_addr = addr; mem_wdata = data; mem_need_to_work = 1'b1; end
    endcase
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if ((src == 0 && boot_work_done) || (src == 1 && if_work_done) || (src == 2 && mem_work_done)) begin
        ok = 1'b1; rd = rdata_out; to_seen = timeout_err; lat_obs = int'(cyc - done_cyc);
      end
    end
    case (src)
      0: boot_need_to_work = 1'b0;
      1: if_need_to_work = 1'b0;
      default: mem_need_to_work = 1'b0;
    endcase
    if (!ok) begin
      checks++; errors++;
      $display("FAIL txn src=%0d addr=%0h: got no done, required done within 600 cycles", src, addr);
    end else if (src == 0 || (src == 2 && we)) begin
      gold[int'(addr)] = data;
    end
  endtask

  typedef struct {
    int          src;
    logic        we;
    logic [17:0] addr;
    logic [15:0] data;
    int          lat;
    logic        exp_we;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        vecs[8];
  int          exp3[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int          got3[10];
  int          n3;
  int          cnt4;
  int          g0;
  logic [15:0] rd;
  logic        tos;
  int          lo;
  bit          seen;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation still running at 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vecs[0] = '{1, 1'b0, 18'h00010, 16'h0000,   2, 1'b0, 16'h1234};
    vecs[1] = '{2, 1'b1, 18'h3FFFF, 16'hBEEF,   1, 1'b1, 16'h1234};
    vecs[2] = '{2, 1'b0, 18'h3FFFF, 16'h0000,   3, 1'b0, 16'hBEEF};
    vecs[3] = '{1, 1'b0, 18'h00001, 16'h0000,   1, 1'b0, 16'hA5A1};
    vecs[4] = '{2, 1'b1, 18'h00020, 16'hCAFE,   4, 1'b1, 16'hA5A1};
    vecs[5] = '{1, 1'b0, 18'h00020, 16'h0000,   2, 1'b0, 16'hCAFE};
    vecs[6] = '{2, 1'b0, 18'h00005, 16'h0000,   2, 1'b0, 16'h5A5F};
    vecs[7] = '{2, 1'b0, 18'h00010, 16'h0000, 255, 1'b0, 16'h1234};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ram_need", ram_need_to_work, 0);
    check("reset ram_bus", {ram_we, ram_addr_out, ram_data_out}, 0);
    check("reset rdata", rdata_out, 0);
    check("reset pulses", {boot_work_done, if_work_done, mem_work_done, timeout_err}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Boot phase: IF held but must wait for boot_done
    if_addr = 18'h00002; if_need_to_work = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lat_cfg = i + 1;
      txn(0, 1'b1, 18'(i), 16'hA5A0 + 16'(i), rd, tos, lo);
      check($sformatf("boot%0d addr", i), log_addr, 18'(i));
      check($sformatf("boot%0d data", i), log_data, 16'hA5A0 + 16'(i));
      check($sformatf("boot%0d we", i), log_we, 1);
    end
    if_addr = 18'h00002; if_need_to_work = 1'b1;
    g0 = grants;
    repeat (5) @(negedge clk);
    check("boot IF held off grants", grants, g0);
    check("boot IF no done", if_done_cnt, 0);
    boot_done = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (if_work_done) begin seen = 1'b1; rd = rdata_out; end
    end
    if_need_to_work = 1'b0;
    check("boot IF served", seen, 1);
    check("boot IF rdata", rd, 16'hA5A2);

    // Vector table
    sram_w[16] = 16'h1234;
    gold[16]   = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      lat_cfg = vecs[i].lat;
      @(negedge clk);
      txn(vecs[i].src, vecs[i].we, vecs[i].addr, vecs[i].data, rd, tos, lo);
      check($sformatf("v%0d ram_addr", i), log_addr, vecs[i].addr);
      check($sformatf("v%0d ram_we", i), log_we, vecs[i].exp_we);
      if (vecs[i].exp_we) check($sformatf("v%0d ram_data", i), log_data, vecs[i].data);
      check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d done latency", i), lo, 1);
      check($sformatf("v%0d timeout_err", i), tos, 0);
    end

    // IF and MEM both held continuously: streak rotation
    lat_cfg = 1;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 18'h00003; if_addr = 18'h00004;
    if_need_to_work = 1'b1; mem_need_to_work = 1'b1;
    n3 = 0;
    for (int k = 0; k < 10; k++) got3[k] = 0;
    for (int i = 0; i < 400 && n3 < 10; i++) begin
      @(negedge clk);
      if (mem_work_done) begin got3[n3] = 2; n3++; end
      else if (if_work_done) begin got3[n3] = 1; n3++; end
    end
    if_need_to_work = 1'b0; mem_need_to_work = 1'b0;
    for (int k = 0; k < 10; k++) check($sformatf("streak grant%0d (1=IF 2=MEM)", k), got3[k], exp3[k]);

    // Timeout: SRAM never answers
    repeat (2) @(negedge clk);
    no_resp = 1'b1;
    mem_we = 1'b0; mem_addr = 18'h00005; mem_need_to_work = 1'b1;
    cnt4 = 0; seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ram_need_to_work) cnt4++;
      else if (cnt4 > 0) seen = 1'b1;
    end
    mem_need_to_work = 1'b0;
    check("timeout busy cycles", cnt4, 255);
    check("timeout_err pulse", timeout_err, 1);
    check("timeout mem_done", mem_work_done, 1);
    check("timeout rdata", rdata_out, 0);
    @(negedge clk);
    check("timeout_err one cycle", timeout_err, 0);
    no_resp = 1'b0; lat_cfg = 2;
    txn(2, 1'b0, 18'h00005, 16'h0, rd, tos, lo);
    check("after timeout rdata", rd, 16'h5A5F);

    // Asynchronous reset during BUSY
    no_resp = 1'b1;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 18'h00001; mem_need_to_work = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ram_need_to_work) seen = 1'b1;
    end
    check("rst test busy", seen, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst ram_need", ram_need_to_work, 0);
    check("async rst ram_bus", {ram_we, ram_addr_out, ram_data_out}, 0);
    check("async rst rdata", rdata_out, 0);
    check("async rst pulses", {boot_work_done, if_work_done, mem_work_done, timeout_err}, 0);
    mem_need_to_work = 1'b0;
    @(negedge clk);
    rst = 1'b1; no_resp = 1'b0;
    repeat (3) @(negedge clk);
    check("post rst idle", ram_need_to_work, 0);
    txn(2, 1'b0, 18'h3FFFF, 16'h0, rd, tos, lo);
    check("post rst read", rd, 16'hBEEF);

    // Randomized IF/MEM traffic against golden memory and arbitration rules
    lat_cfg = 0;
    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    fork
      begin : rnd_if
        logic [17:0] a_i; logic [15:0] rd_i; logic to_i; int lo_i;
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a_i = 18'($urandom_range(0, 15));
          txn(1, 1'b0, a_i, 16'h0, rd_i, to_i, lo_i);
          check("rnd IF rdata", rd_i, gold_rd(a_i));
        end
      end
      begin : rnd_mem
        logic [17:0] a_m; logic [15:0] d_m, rd_m; logic we_m, to_m; int lo_m;
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a_m  = 18'($urandom_range(0, 15));
          d_m  = 16'($urandom);
          we_m = 1'($urandom_range(0, 1));
          txn(2, we_m, a_m, d_m, rd_m, to_m, lo_m);
          if (!we_m) check("rnd MEM rdata", rd_m, gold_rd(a_m));
        end
      end
    join
    repeat (4) @(negedge clk);
    mon_on = 1'b0;
    check("rnd pending grants", exp_q.size(), 0);

    check("ram bus frozen while busy", frozen_err, 0);
    check("done pulses single-cycle and exclusive", pulse_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
